// File: rtl/mem_d4_stream_reader.sv
// mem_d4_stream_reader: walks a runtime-sized 4D box of a Calyx-style std_mem
// in row-major order (addr3 innermost) and streams each word on valid/ready.
// Optional build macro MEM_D4_READER_OUT_REG_EN adds a 2-entry skid buffer so
// out_* are fully registered.
module mem_d4_stream_reader #(
  parameter int WIDTH       = 32,
  parameter int D0_SIZE     = 16,
  parameter int D1_SIZE     = 16,
  parameter int D2_SIZE     = 16,
  parameter int D3_SIZE     = 16,
  parameter int D0_IDX_SIZE = 4,
  parameter int D1_IDX_SIZE = 4,
  parameter int D2_IDX_SIZE = 4,
  parameter int D3_IDX_SIZE = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   go,
  input  logic [D0_IDX_SIZE:0]   len0,
  input  logic [D1_IDX_SIZE:0]   len1,
  input  logic [D2_IDX_SIZE:0]   len2,
  input  logic [D3_IDX_SIZE:0]   len3,
  output logic [D0_IDX_SIZE-1:0] addr0,
  output logic [D1_IDX_SIZE-1:0] addr1,
  output logic [D2_IDX_SIZE-1:0] addr2,
  output logic [D3_IDX_SIZE-1:0] addr3,
  output logic                   write_en,
  input  logic [WIDTH-1:0]       mem_read_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic                   done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  // Per-dimension last index (clamped len - 1) and current index
  logic [D0_IDX_SIZE-1:0] lim0_q, lim0_d, idx0_q, idx0_d;
  logic [D1_IDX_SIZE-1:0] lim1_q, lim1_d, idx1_q, idx1_d;
  logic [D2_IDX_SIZE-1:0] lim2_q, lim2_d, idx2_q, idx2_d;
  logic [D3_IDX_SIZE-1:0] lim3_q, lim3_d, idx3_q, idx3_d;

  logic at_end;  // current indices address the final word of the box
  logic fetch;   // memory word handed off this cycle
  logic finish;  // final word leaves the block this cycle
  logic start;

  // Zero-length means one element; oversize lengths clamp to the memory extent
  function automatic int unsigned clamp_lim(input int unsigned len, input int unsigned size);
    if (len == 0)        return 0;
    else if (len > size) return size - 1;
    else                 return len - 1;
  endfunction

  assign at_end = (idx0_q == lim0_q) && (idx1_q == lim1_q) &&
                  (idx2_q == lim2_q) && (idx3_q == lim3_q);
  assign start  = (state_q == S_IDLE) && go;

`ifdef MEM_D4_READER_OUT_REG_EN
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic             last0_q, last0_d, last1_q, last1_d;
  logic             more_q, more_d;
  logic             pop;

  assign pop    = (cnt_q != 2'd0) && out_ready;
  assign fetch  = (state_q == S_RUN) && more_q && ((cnt_q != 2'd2) || pop);
  assign finish = pop && last0_q;

  // Skid buffer: head entry drives the stream, pushes land behind any survivor
  always_comb begin
    cnt_d   = cnt_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    more_d  = more_q;
    if (start)
      more_d = 1'b1;
    else if (fetch && at_end)
      more_d = 1'b0;
    case ({fetch, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          buf0_d  = mem_read_data;
          last0_d = at_end;
        end else begin
          buf1_d  = mem_read_data;
          last1_d = at_end;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d  = buf1_q;
        last0_d = last1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          buf0_d  = mem_read_data;
          last0_d = at_end;
        end else begin
          buf0_d  = buf1_q;
          last0_d = last1_q;
          buf1_d  = mem_read_data;
          last1_d = at_end;
        end
      end
      default: ;
    endcase
  end

  // Skid buffer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      more_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
      more_q  <= more_d;
    end
  end
`else
  assign fetch  = (state_q == S_RUN) && out_ready;
  assign finish = fetch && at_end;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_RUN;
      S_RUN:   if (finish) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Index walk: latch limits on start, ripple-carry increment on each fetch
  always_comb begin
    lim0_d = lim0_q;
    lim1_d = lim1_q;
    lim2_d = lim2_q;
    lim3_d = lim3_q;
    idx0_d = idx0_q;
    idx1_d = idx1_q;
    idx2_d = idx2_q;
    idx3_d = idx3_q;
    if (start) begin
      lim0_d = D0_IDX_SIZE'(clamp_lim(32'(len0), D0_SIZE));
      lim1_d = D1_IDX_SIZE'(clamp_lim(32'(len1), D1_SIZE));
      lim2_d = D2_IDX_SIZE'(clamp_lim(32'(len2), D2_SIZE));
      lim3_d = D3_IDX_SIZE'(clamp_lim(32'(len3), D3_SIZE));
      idx0_d = '0;
      idx1_d = '0;
      idx2_d = '0;
      idx3_d = '0;
    end else if (fetch && !at_end) begin
      if (idx3_q != lim3_q) begin
        idx3_d = idx3_q + 1'b1;
      end else begin
        idx3_d = '0;
        if (idx2_q != lim2_q) begin
          idx2_d = idx2_q + 1'b1;
        end else begin
          idx2_d = '0;
          if (idx1_q != lim1_q) begin
            idx1_d = idx1_q + 1'b1;
          end else begin
            idx1_d = '0;
            idx0_d = idx0_q + 1'b1;
          end
        end
      end
    end
  end

  // Index and limit registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lim0_q <= '0;
      lim1_q <= '0;
      lim2_q <= '0;
      lim3_q <= '0;
      idx0_q <= '0;
      idx1_q <= '0;
      idx2_q <= '0;
      idx3_q <= '0;
    end else begin
      lim0_q <= lim0_d;
      lim1_q <= lim1_d;
      lim2_q <= lim2_d;
      lim3_q <= lim3_d;
      idx0_q <= idx0_d;
      idx1_q <= idx1_d;
      idx2_q <= idx2_d;
      idx3_q <= idx3_d;
    end
  end

  // Output decode
  always_comb begin
    addr0    = idx0_q;
    addr1    = idx1_q;
    addr2    = idx2_q;
    addr3    = idx3_q;
    write_en = 1'b0;
    done     = (state_q == S_DONE);
`ifdef MEM_D4_READER_OUT_REG_EN
    out_valid = (cnt_q != 2'd0);
    out_data  = buf0_q;
    out_last  = last0_q && (cnt_q != 2'd0);
`else
    out_valid = (state_q == S_RUN);
    out_data  = mem_read_data;
    out_last  = (state_q == S_RUN) && at_end;
`endif
  end

endmodule

// File: doc/mem_d4_stream_reader.md
# mem_d4_stream_reader

Initiator-side controller for a four-dimensional Calyx-style memory: on `go` it walks a runtime-sized 4D index box in row-major order, driving the memory's `addr0..addr3` and `write_en`, and streams each combinationally-returned word out on a valid/ready port. It connects directly to the address, write and read-data pins of a 4D `std_mem` instance. It sits between that memory and downstream streaming datapath logic.

## Interface
- `WIDTH`, 32, data word width
- `D0_SIZE`..`D3_SIZE`, 16 each, memory extent per dimension
- `D0_IDX_SIZE`..`D3_IDX_SIZE`, 4 each, address width per dimension
- `clk`  in  1  clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `go`  in  1  start pulse; sampled only in IDLE
- `len0`..`len3`  in  `Dn_IDX_SIZE+1`  box extent per dimension, latched on accepted `go`
- `addr0`..`addr3`  out  `Dn_IDX_SIZE`  memory address
- `write_en`  out  1  memory write enable; constant 0
- `mem_read_data`  in  `WIDTH`  memory combinational read port
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  downstream accept
- `out_data`  out  `WIDTH`  stream word
- `out_last`  out  1  marks final word of the box
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM: IDLE -> RUN on `go`; RUN -> DONE after final word handshake; DONE -> IDLE unconditionally next cycle.
- On accepted `go`: latch lens, zero all indices. Len of 0 treated as 1; len > `Dn_SIZE` clamped to `Dn_SIZE`.
- `go` in RUN or DONE ignored; lens are not re-latched.
- Walk order row-major: `addr3` innermost. `addr3` wraps at len3-1 -> 0 and carries into `addr2`, and so on up to `addr0`.
- A fetch advances the indices only when the word is handed off (handshake, or buffer accept under the macro).
- `out_last` = 1 with the word whose indices are all at lenN-1.
- Total words = product of clamped lens; exactly that many handshakes per run. No duplicates, no skips.
- `addr*` hold their last value in IDLE/DONE; zeroed on `go`.
- `write_en` tied 0 in every state and under reset.
- `out_valid` never drops without a handshake; `out_data` and `out_last` are stable while `out_valid && !out_ready`.

## Timing
- Reset values: state IDLE, `addr*` 0, `out_valid` 0, `out_last` 0, `done` 0.
- `reset_n` low mid-run aborts immediately; no `done` pulse; buffer emptied.
- Macro off: first `out_valid` on the cycle after `go`. Throughput is 1 word/cycle with `out_ready` held high.
- Macro on: first `out_valid` 2 cycles after `go`. Throughput is 1 word/cycle when the buffer is steady.
- `done` is high for exactly the cycle after the final handshake; `out_valid` is 0 in that cycle.
- Back-to-back: `go` in the cycle `done` is high is ignored. `go` in the following IDLE cycle starts a new run.
- 1x1x1x1 box: one word with `out_last`=1, then `done`.

## Configuration
- `MEM_D4_READER_OUT_REG_EN` undefined:
  - `out_data` = `mem_read_data` combinationally.
  - `out_valid` = (state==RUN).
  - Indices advance on `out_valid && out_ready`.
- `MEM_D4_READER_OUT_REG_EN` defined:
  - A 2-entry skid buffer registers `out_data`/`out_last`.
  - Memory is fetched whenever in RUN with words remaining and the buffer has room (count<2, or a pop occurs the same cycle).
  - The FSM leaves RUN when the last word pops from the buffer.
  - No combinational path from `mem_read_data` or `out_ready` to `out_*`.

## Test plan
- Lens 2,1,1,3, memory preloaded with word = index, `out_ready`=1 -> 6 words in order (0,0,0,0),(0,0,0,1),(0,0,0,2),(1,0,0,0),(1,0,0,1),(1,0,0,2); `out_last` on the 6th; `done` one cycle later.
- Same run with `out_ready` toggling 1,0,0,1 repeating -> same 6 words; data stable during stalls; no loss or duplication in either macro build.
- Lens 0,0,0,0 and lens 17,1,1,1 -> 1 word; and 16 words with `addr0` 0..15 (clamp).
- Reset asserted after the 3rd handshake of a 12-word run -> all outputs 0 asynchronously; no `done`; next `go` restarts at index 0.
- `go` pulsed during RUN and during the `done` cycle -> ignored; `write_en` observed 0 throughout.
- Full 16x16x16x16 box, random `out_ready` -> 65536 words; single `out_last`; word checksum matches memory.
